// File: rtl/gpio_ahb_arbiter.sv
// gpio_ahb_arbiter: round-robin AHB-Lite arbiter with hold limit for the GPIO slave port (optional lock via GPIO_ARB_LOCK_EN)
module gpio_ahb_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int MAX_HOLD    = 16
) (
    input  logic                   i_hclk,
    input  logic                   i_hresetn,
    input  logic [NUM_MASTERS-1:0] i_hbusreq,
    input  logic [NUM_MASTERS-1:0] i_hlock,
    input  logic [1:0]             i_htrans,
    input  logic                   i_hready,
    output logic [NUM_MASTERS-1:0] o_hgrant,
    output logic [1:0]             o_hmaster,
    output logic                   o_hmastlock
);
`ifdef GPIO_ARB_LOCK_EN
    typedef enum logic [1:0] {PARK, OWN, LOCKED} state_t;
`else
    typedef enum logic [1:0] {PARK, OWN} state_t;
`endif
    localparam logic [NUM_MASTERS-1:0] GRANT0 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    state_t                   r_state, w_next_state;
    logic [1:0]               r_idx, w_next_idx, w_sel, r_master;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic [7:0]               r_hold;
    logic                     w_found, w_arb, w_others, w_keep;
    logic                     w_sel_lock, w_own_lock;
    int                       w_dist, w_best;
    assign w_others = |(i_hbusreq & ~r_grant);
    // nearest requester above the owner, wrapping; the owner itself is found last
    always_comb begin
        w_found    = 1'b0;
        w_sel      = '0;
        w_best     = NUM_MASTERS;
        w_dist     = 0;
        w_sel_lock = 1'b0;
        w_own_lock = 1'b0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            w_dist = (m + 2 * NUM_MASTERS - 1 - int'(r_idx)) % NUM_MASTERS;
            if (i_hbusreq[m] && w_dist < w_best) begin
                w_found    = 1'b1;
                w_sel      = 2'(m);
                w_best     = w_dist;
                w_sel_lock = i_hlock[m];
            end
            if (2'(m) == r_idx) w_own_lock = i_hlock[m];
        end
    end
    // arbitration point detection and next owner/state
    always_comb begin
        w_arb        = i_hready && (i_htrans == 2'd0 || i_htrans == 2'd2 ||
                       (r_state == OWN && r_hold == 8'(MAX_HOLD)));
`ifdef GPIO_ARB_LOCK_EN
        w_keep       = r_state == LOCKED && w_own_lock;
`else
        w_keep       = 1'b0;
`endif
        w_next_state = r_state;
        w_next_idx   = r_idx;
        if (w_arb && !w_keep) begin
            w_next_idx   = w_found ? w_sel : 2'd0;
            w_next_state = !w_found ? PARK : OWN;
`ifdef GPIO_ARB_LOCK_EN
            if (w_found && w_sel_lock) w_next_state = LOCKED;
`endif
        end
    end
    // state, owner index and one-hot grant registers
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn) begin
            r_state <= PARK;
            r_idx   <= '0;
            r_grant <= GRANT0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_grant <= GRANT0 << w_next_idx;
        end
    end
    // hold counter: clears on handover, counts contended ready cycles while owned, saturates
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn)
            r_hold <= '0;
        else if (w_next_idx != r_idx)
            r_hold <= '0;
        else if (r_state == OWN && i_hready && w_others && r_hold != 8'(MAX_HOLD))
            r_hold <= r_hold + 8'd1;
    end
    // address-phase owner follows the grant only on ready edges
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn)
            r_master <= '0;
        else if (i_hready)
            r_master <= r_idx;
    end
`ifdef GPIO_ARB_LOCK_EN
    logic r_mastlock;
    // locked indication travels with the address phase
    always_ff @(posedge i_hclk or negedge i_hresetn) begin
        if (!i_hresetn)
            r_mastlock <= 1'b0;
        else if (i_hready)
            r_mastlock <= r_state == LOCKED;
    end
    assign o_hmastlock = r_mastlock;
`else
    logic w_unused_lock;
    assign w_unused_lock = ^{i_hlock, w_sel_lock, w_own_lock};
    assign o_hmastlock   = 1'b0;
`endif
    assign o_hgrant  = r_grant;
    assign o_hmaster = r_master;
endmodule

// File: tb/tb_gpio_ahb_arbiter.sv
// tb_gpio_ahb_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model
module tb_gpio_ahb_arbiter;
    localparam int NM = 3;
    localparam int MH = 4;
`ifdef GPIO_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    logic          i_hclk = 1'b0;
    logic          i_hresetn = 1'b0;
    logic [NM-1:0] i_hbusreq = '0;
    logic [NM-1:0] i_hlock = '0;
    logic [1:0]    i_htrans = 2'd0;
    logic          i_hready = 1'b1;
    logic [NM-1:0] o_hgrant;
    logic [1:0]    o_hmaster;
    logic          o_hmastlock;
    int n_tests = 0;
    int n_fail = 0;
    int m_owner, m_hold, m_master;
    bit m_locked, m_parked, m_mlock;

    gpio_ahb_arbiter #(.NUM_MASTERS(NM), .MAX_HOLD(MH)) dut (
        .i_hclk(i_hclk), .i_hresetn(i_hresetn), .i_hbusreq(i_hbusreq), .i_hlock(i_hlock),
        .i_htrans(i_htrans), .i_hready(i_hready), .o_hgrant(o_hgrant), .o_hmaster(o_hmaster),
        .o_hmastlock(o_hmastlock)
    );

    always #5 i_hclk = ~i_hclk;

    task automatic mdl_reset();
        m_owner = 0; m_hold = 0; m_master = 0; m_locked = 0; m_parked = 1; m_mlock = 0;
    endtask

    task automatic mdl_update();
        int nxt;
        bit nlocked, nparked, arb, others;
        nxt = m_owner; nlocked = m_locked; nparked = m_parked;
        others = (i_hbusreq & ~(NM'(1) << m_owner)) != 0;
        arb = i_hready && (i_htrans == 2'd0 || i_htrans == 2'd2 ||
              (!m_parked && !m_locked && m_hold == MH));
        if (arb && !(m_locked && i_hlock[m_owner])) begin
            nxt = 0; nparked = 1; nlocked = 0;
            for (int k = 1; k <= NM; k++)
                if (nparked && i_hbusreq[(m_owner + k) % NM]) begin
                    nxt = (m_owner + k) % NM;
                    nparked = 0;
                    nlocked = LOCK_EN && i_hlock[nxt];
                end
        end
        if (i_hready) begin
            m_master = m_owner;
            m_mlock = m_locked;
        end
        if (nxt != m_owner) m_hold = 0;
        else if (!m_parked && !m_locked && i_hready && others && m_hold < MH) m_hold++;
        m_owner = nxt; m_locked = nlocked; m_parked = nparked;
    endtask

    task automatic step();
        mdl_update();
        @(posedge i_hclk);
        #1;
        n_tests++;
        if (o_hgrant !== NM'(1) << m_owner) begin
            n_fail++;
            $display("FAIL model_grant got=%b exp=%b t=%0t", o_hgrant, NM'(1) << m_owner, $time);
        end
        n_tests++;
        if (o_hmaster !== 2'(m_master)) begin
            n_fail++;
            $display("FAIL model_master got=%0d exp=%0d t=%0t", o_hmaster, m_master, $time);
        end
        n_tests++;
        if (o_hmastlock !== m_mlock) begin
            n_fail++;
            $display("FAIL model_mastlock got=%b exp=%b t=%0t", o_hmastlock, m_mlock, $time);
        end
    endtask

    task automatic do_reset();
        i_hresetn = 1'b0; i_hbusreq = '0; i_hlock = '0; i_htrans = 2'd0; i_hready = 1'b1;
        mdl_reset();
        repeat (2) @(posedge i_hclk);
        #1 i_hresetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (o_hgrant !== 3'b001 || o_hmaster !== 2'd0 || o_hmastlock !== 1'b0) begin
            n_fail++;
            $display("FAIL reset got=%b/%0d/%b exp=001/0/0", o_hgrant, o_hmaster, o_hmastlock);
        end
        step();
    endtask

    task automatic test_basic();
        do_reset();
        i_hbusreq = 3'b010; i_htrans = 2'd0;
        step();
        n_tests++;
        if (o_hgrant !== 3'b010 || o_hmaster !== 2'd0) begin
            n_fail++;
            $display("FAIL basic_grant got=%b/%0d exp=010/0", o_hgrant, o_hmaster);
        end
        step();
        n_tests++;
        if (o_hmaster !== 2'd1) begin
            n_fail++;
            $display("FAIL basic_master got=%0d exp=1", o_hmaster);
        end
    endtask

    task automatic test_contention();
        do_reset();
        i_hbusreq = 3'b011; i_htrans = 2'd2;
        for (int i = 0; i < 8; i++) begin
            step();
            n_tests++;
            if (o_hgrant !== ((i % 2 == 0) ? 3'b010 : 3'b001)) begin
                n_fail++;
                $display("FAIL contention_%0d got=%b exp=%b", i, o_hgrant, (i % 2 == 0) ? 3'b010 : 3'b001);
            end
        end
    endtask

    task automatic test_rotation();
        logic [NM-1:0] exp_seq [4];
        exp_seq = '{3'b010, 3'b100, 3'b001, 3'b010};
        do_reset();
        i_hbusreq = 3'b111; i_htrans = 2'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (o_hgrant !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL rotation_%0d got=%b exp=%b", i, o_hgrant, exp_seq[i]);
            end
        end
    endtask

    task automatic test_hold_limit();
        int cnt;
        do_reset();
        i_hbusreq = 3'b001; i_htrans = 2'd2;
        step();
        i_hbusreq = 3'b011; i_htrans = 2'd3;
        cnt = 0;
        while (o_hgrant !== 3'b010 && cnt < 12) begin
            step();
            cnt++;
        end
        n_tests++;
        if (cnt != MH + 1) begin
            n_fail++;
            $display("FAIL hold_limit handover_after=%0d exp=%0d", cnt, MH + 1);
        end
    endtask

    task automatic test_lock();
        do_reset();
        i_hbusreq = 3'b001; i_hlock = 3'b001; i_htrans = 2'd2;
        step();
        i_hbusreq = 3'b011;
        for (int i = 0; i < 20; i++) begin
            step();
            n_tests++;
            if (o_hmastlock !== LOCK_EN) begin
                n_fail++;
                $display("FAIL lock_mastlock_%0d got=%b exp=%b", i, o_hmastlock, LOCK_EN);
            end
`ifdef GPIO_ARB_LOCK_EN
            n_tests++;
            if (o_hgrant !== 3'b001) begin
                n_fail++;
                $display("FAIL lock_hold_%0d got=%b exp=001", i, o_hgrant);
            end
`endif
        end
        i_hlock = 3'b000;
        step();
`ifdef GPIO_ARB_LOCK_EN
        n_tests++;
        if (o_hgrant !== 3'b010) begin
            n_fail++;
            $display("FAIL lock_release got=%b exp=010", o_hgrant);
        end
`endif
    endtask

    task automatic test_wait_states();
        do_reset();
        i_hbusreq = 3'b010; i_htrans = 2'd0; i_hready = 1'b0;
        repeat (3) step();
        n_tests++;
        if (o_hgrant !== 3'b001) begin
            n_fail++;
            $display("FAIL wait_nograntchg got=%b exp=001", o_hgrant);
        end
        i_hready = 1'b1;
        step();
        i_hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (o_hmaster !== 2'd0 || o_hgrant !== 3'b010) begin
                n_fail++;
                $display("FAIL wait_hold_%0d got=%0d/%b exp=0/010", i, o_hmaster, o_hgrant);
            end
        end
        i_hready = 1'b1;
        step();
        n_tests++;
        if (o_hmaster !== 2'd1) begin
            n_fail++;
            $display("FAIL wait_release got=%0d exp=1", o_hmaster);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        i_hbusreq = 3'b100; i_hlock = 3'b100; i_htrans = 2'd2;
        step();
        i_htrans = 2'd3;
        repeat (2) step();
        #2 i_hresetn = 1'b0;
        #1;
        n_tests++;
        if (o_hgrant !== 3'b001 || o_hmaster !== 2'd0 || o_hmastlock !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got=%b/%0d/%b exp=001/0/0", o_hgrant, o_hmaster, o_hmastlock);
        end
        i_hbusreq = '0; i_hlock = '0; i_htrans = 2'd0;
        mdl_reset();
        @(posedge i_hclk);
        #1 i_hresetn = 1'b1;
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            i_hbusreq = NM'($urandom);
            i_hlock   = ($urandom_range(0, 3) == 0) ? NM'($urandom) : i_hlock & NM'($urandom);
            i_htrans  = 2'($urandom);
            i_hready  = $urandom_range(0, 4) != 0;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_contention();
        test_rotation();
        test_hold_limit();
        test_lock();
        test_wait_states();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gpio_ahb_arbiter.md
# gpio_ahb_arbiter

AHB-Lite bus arbiter that shares the GPIO peripheral's slave port between up to four bus masters (CPU, DMA, debug). It owns HGRANT/HMASTER/HMASTLOCK generation, handing the bus over only at transfer boundaries with round-robin fairness and a hold limit. It sits between the master-side address/data muxes and the GPIO slave, and the masters' address/data multiplexers select on HMASTER.

## Interface
- NUM_MASTERS, 2: number of requesting masters; legal values 2..4.
- MAX_HOLD, 16: maximum consecutive granted address phases for one master while another master requests; legal values 2..255.
- HCLK  input  1  bus clock; all state updates on its rising edge.
- HRESETn  input  1  reset, asynchronous, active-low.
- HBUSREQ  input  NUM_MASTERS  per-master bus request.
- HLOCK  input  NUM_MASTERS  per-master locked-transfer request, valid with HBUSREQ.
- HTRANS  input  2  transfer type of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HREADY  input  1  bus ready; advances address/data phases.
- HGRANT  output  NUM_MASTERS  one-hot grant, registered.
- HMASTER  output  2  index of the master owning the address phase, registered.
- HMASTLOCK  output  1  the current address phase is locked, registered.

## Operation
- Reset values: HGRANT = 1 (master 0 parked), HMASTER = 0, HMASTLOCK = 0, hold counter = 0, round-robin pointer = 0.
- States: PARK (no requests, grant to master 0), OWN (grant to a requester), LOCKED (owner holds HLOCK).
- Arbitration point: HREADY=1 and HTRANS is IDLE or NONSEQ, or the hold limit is reached. BUSY and SEQ never allow handover, except on hold expiry.
- Selection: round-robin over HBUSREQ, searching upward from current owner+1 modulo NUM_MASTERS. If no master requests, the grant goes to master 0 and the state is PARK.
- The current owner keeps the grant if it still requests and no other master requests.
- Hold counter: it increments on each HREADY=1 cycle while the owner is in OWN and another master requests. It clears on every grant change, and it saturates at MAX_HOLD.
- Hold expiry: when the counter equals MAX_HOLD, the next HREADY=1 cycle is a forced arbitration point, even mid-burst. The owner must rebuild its burst.
- LOCKED: entered when the granted owner has HLOCK=1 at an arbitration point. In LOCKED, no handover and no hold expiry occur. The state exits at the first arbitration point with the owner's HLOCK=0.
- HMASTER: loads the index of the one-hot HGRANT on each rising edge with HREADY=1. It holds during wait states.
- HMASTLOCK: loads (state==LOCKED) on the same HREADY=1 edge as HMASTER.
- Bits of HBUSREQ and HLOCK above NUM_MASTERS-1 do not exist. Indices at or above NUM_MASTERS never appear on HMASTER.

## Timing
- Grant latency: with a request sampled at an arbitration point on edge N, HGRANT changes on edge N+1. HMASTER follows on the first later edge with HREADY=1.
- With HREADY held low, HGRANT may change at most once. No further arbitration happens until HREADY=1.
- Simultaneous requests from all masters starting in PARK: grants go 1, 2, …, 0 in rotation. Each master receives at least one address phase per rotation.
- Deassertion of HBUSREQ by the owner at an arbitration point gives the grant to the next requester on the next edge, or to PARK if there is none.
- Reset asserted mid-transfer: all outputs take reset values immediately, without waiting for a clock edge. Lock and counter state are discarded.

## Configuration
- GPIO_ARB_LOCK_EN defined: HLOCK is honoured, the LOCKED state exists, and HMASTLOCK is driven as described above.
- GPIO_ARB_LOCK_EN undefined: HLOCK is ignored, the LOCKED state is removed, and HMASTLOCK is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset check: after reset with HBUSREQ=0 → HGRANT=01, HMASTER=0, HMASTLOCK=0.
- Basic request: master 1 requests, HTRANS=IDLE, HREADY=1 → HGRANT=10 one edge later, HMASTER=1 on the following edge.
- Contention: both masters request continuously with NONSEQ single transfers → grants alternate 01/10 on every arbitration point.
- Hold limit: master 0 runs a SEQ burst while master 1 requests, MAX_HOLD=4 → handover after exactly 4 HREADY=1 address phases, despite SEQ.
- Locked transfer (GPIO_ARB_LOCK_EN): master 0 asserts HLOCK for 20 beats while master 1 requests → no handover and HMASTLOCK=1 throughout. Handover follows the first arbitration point after HLOCK drops.
- Wait states and reset: HREADY=0 for 3 cycles during a requested handover → HMASTER stays unchanged until HREADY=1. Asserting HRESETn=0 mid-burst → outputs return to reset values asynchronously.
